// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus responder: FSM states,
// latched operation codes, default widths and the wait-count limit.
package mem_bus_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int MAX_WAIT   = 15;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_ROM_RD = 2'd0,
        OP_RAM_RD = 2'd1,
        OP_RAM_WR = 2'd2
    } op_t;

    // Out-of-range wait parameters saturate at the counter limit
    function automatic logic [CNT_W-1:0] to_wait_cnt(input int w);
        return (w > MAX_WAIT) ? CNT_W'(MAX_WAIT) : CNT_W'(w);
    endfunction

endpackage

// File: rtl/mem_sp_array.sv
// Single-port storage array: synchronous write, read indexed combinationally
// so the parent can capture the word on the same edge that commits the access.
module mem_sp_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];

    // Storage write port; contents intentionally have no reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: decodes controller strobes in IDLE, counts wait
// states, commits the access on entry to RESP and pulses rdy for one cycle.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ena,
    input  logic              rom_read,
    input  logic              ram_ena,
    input  logic              ram_read,
    input  logic              ram_write,
    input  logic              ad_sel,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] ir_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] rdata,
    output logic              rdy,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] ROM_WAIT_C = to_wait_cnt(ROM_WAIT);
    localparam logic [CNT_W-1:0] RAM_WAIT_C = to_wait_cnt(RAM_WAIT);

    state_t            state_r, state_next_s;
    op_t               op_r, req_op_s, acc_op_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s, req_wait_s;
    logic [ADDR_W-1:0] addr_r, req_addr_s, acc_addr_s, rom_addr_s;
    logic [DATA_W-1:0] wdata_r, acc_wdata_s, rom_q_s, ram_q_s;
    logic [1:0]        req_cnt_s;
    logic              rr_s, mr_s, mw_s;
    logic              load_s, accept_s, illegal_s, enter_resp_s, rom_we_s, ram_we_s;

    // Request decode, preload priority and selection of the accepted operation
    always_comb begin
        rr_s       = rom_ena & rom_read;
        mr_s       = ram_ena & ram_read;
        mw_s       = ram_ena & ram_write;
        req_cnt_s  = {1'b0, rr_s} + {1'b0, mr_s} + {1'b0, mw_s};
        load_s     = (state_r == IDLE) && ld_en;
        accept_s   = (state_r == IDLE) && !ld_en && (req_cnt_s == 2'd1);
        illegal_s  = (state_r == IDLE) && !ld_en && (req_cnt_s >= 2'd2);
        req_addr_s = ad_sel ? ir_addr : pc_addr;
        if (rr_s) begin
            req_op_s   = OP_ROM_RD;
            req_wait_s = ROM_WAIT_C;
        end else if (mr_s) begin
            req_op_s   = OP_RAM_RD;
            req_wait_s = RAM_WAIT_C;
        end else begin
            req_op_s   = OP_RAM_WR;
            req_wait_s = RAM_WAIT_C;
        end
    end

    // Next-state and wait-counter logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    cnt_next_s   = req_wait_s;
                    state_next_s = (req_wait_s == {CNT_W{1'b0}}) ? RESP : WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = RESP;
                end else begin
                    cnt_next_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    state_next_s = WAIT;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // A zero-wait access commits on its accepting edge, so it uses the live request
    always_comb begin
        if (state_r == IDLE) begin
            acc_op_s    = req_op_s;
            acc_addr_s  = req_addr_s;
            acc_wdata_s = wdata;
        end else begin
            acc_op_s    = op_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
        enter_resp_s = (state_next_s == RESP);
        ram_we_s     = enter_resp_s && (acc_op_s == OP_RAM_WR);
        rom_we_s     = load_s;
        rom_addr_s   = load_s ? ld_addr : acc_addr_s;
    end

    // FSM state, wait counter and latched request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= OP_ROM_RD;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (accept_s) begin
                op_r    <= req_op_s;
                addr_r  <= req_addr_s;
                wdata_r <= wdata;
            end
        end
    end

    // Registered outputs; rdata only moves on a completing read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= {DATA_W{1'b0}};
            rdy   <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            rdy  <= enter_resp_s;
            busy <= (state_next_s != IDLE);
            err  <= illegal_s;
            if (enter_resp_s && (acc_op_s == OP_ROM_RD)) begin
                rdata <= rom_q_s;
            end else if (enter_resp_s && (acc_op_s == OP_RAM_RD)) begin
                rdata <= ram_q_s;
            end
        end
    end

    mem_sp_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rom (
        .clk   (clk),
        .we    (rom_we_s),
        .addr  (rom_addr_s),
        .wdata (ld_data),
        .rdata (rom_q_s)
    );

    mem_sp_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (acc_addr_s),
        .wdata (acc_wdata_s),
        .rdata (ram_q_s)
    );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench: table of accesses with inline timing checks, a
// read-data scoreboard on rdy, plus reset-abort and zero-wait sequences.
module tb_mem_bus_responder;

    localparam int K_LOAD = 0, K_ROM = 1, K_RAMRD = 2, K_RAMWR = 3;
    localparam int K_ILL = 4, K_ILL2 = 5, K_LOADREQ = 6;

    typedef struct {
        int         kind;
        logic       ad_sel;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rdata;
        int         w;
        logic       noise;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rom_ena = 1'b0, rom_read = 1'b0, rom_ena0 = 1'b0;
    logic       ram_ena = 1'b0, ram_read = 1'b0, ram_write = 1'b0;
    logic       ad_sel = 1'b0, ld_en = 1'b0;
    logic [7:0] pc_addr = 8'h00, ir_addr = 8'h00, wdata = 8'h00;
    logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;
    logic [7:0] rdata, rdata0;
    logic       rdy, busy, err, rdy0, busy0, err0;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb_q[$];
    vec_t       tab[14];

    always #5 clk = ~clk;

    mem_bus_responder dut (
        .clk(clk), .rst(rst), .rom_ena(rom_ena), .rom_read(rom_read),
        .ram_ena(ram_ena), .ram_read(ram_read), .ram_write(ram_write),
        .ad_sel(ad_sel), .pc_addr(pc_addr), .ir_addr(ir_addr), .wdata(wdata),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rdata(rdata), .rdy(rdy), .busy(busy), .err(err)
    );

    mem_bus_responder #(.ROM_WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .rom_ena(rom_ena0), .rom_read(rom_read),
        .ram_ena(ram_ena), .ram_read(ram_read), .ram_write(ram_write),
        .ad_sel(ad_sel), .pc_addr(pc_addr), .ir_addr(ir_addr), .wdata(wdata),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rdata(rdata0), .rdy(rdy0), .busy(busy0), .err(err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every rdy of the main instance consumes one expected rdata
    always @(negedge clk) begin
        if (rdy === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_rdy", {31'd0, rdy}, 32'd0);
            end else begin
                check("sb_rdata", {24'd0, rdata}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        rom_ena = 1'b0; rom_read = 1'b0; ram_ena = 1'b0; ram_read = 1'b0;
        ram_write = 1'b0; ld_en = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        clear_inputs();
        ad_sel  = v.ad_sel;
        pc_addr = v.ad_sel ? ~v.addr : v.addr;
        ir_addr = v.ad_sel ? v.addr : ~v.addr;
        wdata   = v.data;
        case (v.kind)
            K_LOAD:    begin ld_en = 1'b1; ld_addr = v.addr; ld_data = v.data; end
            K_LOADREQ: begin ld_en = 1'b1; ld_addr = v.addr; ld_data = v.data;
                             rom_ena = 1'b1; rom_read = 1'b1; end
            K_ROM:     begin rom_ena = 1'b1; rom_read = 1'b1; end
            K_RAMRD:   begin ram_ena = 1'b1; ram_read = 1'b1; end
            K_RAMWR:   begin ram_ena = 1'b1; ram_write = 1'b1; end
            K_ILL:     begin ram_ena = 1'b1; ram_read = 1'b1; ram_write = 1'b1; end
            default:   begin rom_ena = 1'b1; rom_read = 1'b1; ram_ena = 1'b1; ram_write = 1'b1; end
        endcase
    endtask

    task automatic do_access(input int idx, input vec_t v);
        drive(v);
        if (v.kind == K_ROM || v.kind == K_RAMRD || v.kind == K_RAMWR) begin
            sb_q.push_back(v.exp_rdata);
        end
        @(posedge clk); #1;
        clear_inputs();
        if (v.kind == K_LOAD || v.kind == K_LOADREQ) begin
            check($sformatf("v%0d_load_busy", idx), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_load_err", idx), {31'd0, err}, 32'd0);
        end else if (v.kind == K_ILL || v.kind == K_ILL2) begin
            check($sformatf("v%0d_ill_err", idx), {31'd0, err}, 32'd1);
            check($sformatf("v%0d_ill_busy", idx), {31'd0, busy}, 32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_ill_err_clr", idx), {31'd0, err}, 32'd0);
            check($sformatf("v%0d_ill_busy2", idx), {31'd0, busy}, 32'd0);
        end else begin
            for (int k = 0; k <= v.w + 1; k++) begin
                if (k > 0) begin
                    @(posedge clk); #1;
                end
                check($sformatf("v%0d_busy_k%0d", idx, k), {31'd0, busy}, (k <= v.w) ? 32'd1 : 32'd0);
                check($sformatf("v%0d_rdy_k%0d", idx, k), {31'd0, rdy}, (k == v.w) ? 32'd1 : 32'd0);
                check($sformatf("v%0d_err_k%0d", idx, k), {31'd0, err}, 32'd0);
                if (v.noise && k == 0 && v.w > 0) begin
                    ram_ena = 1'b1; ram_write = 1'b1; ad_sel = 1'b1; ir_addr = 8'h10; wdata = 8'hEE;
                    ld_en = 1'b1; ld_addr = 8'h03; ld_data = 8'hEE;
                end
                if (v.noise && k == v.w) begin
                    clear_inputs();
                end
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic [7:0] exp_rd;
        tab[0]  = '{K_LOAD,    1'b0, 8'h03, 8'h5A, 8'h00, 0, 1'b0};
        tab[1]  = '{K_LOAD,    1'b0, 8'h04, 8'hA5, 8'h00, 0, 1'b0};
        tab[2]  = '{K_ROM,     1'b0, 8'h03, 8'h00, 8'h5A, 1, 1'b0};
        tab[3]  = '{K_RAMWR,   1'b1, 8'h10, 8'hC3, 8'h5A, 2, 1'b0};
        tab[4]  = '{K_RAMRD,   1'b1, 8'h10, 8'h00, 8'hC3, 2, 1'b1};
        tab[5]  = '{K_RAMWR,   1'b0, 8'h05, 8'h11, 8'hC3, 2, 1'b0};
        tab[6]  = '{K_RAMRD,   1'b0, 8'h05, 8'h00, 8'h11, 2, 1'b0};
        tab[7]  = '{K_ILL,     1'b0, 8'h10, 8'h77, 8'h00, 0, 1'b0};
        tab[8]  = '{K_RAMRD,   1'b1, 8'h10, 8'h00, 8'hC3, 2, 1'b0};
        tab[9]  = '{K_LOADREQ, 1'b0, 8'h04, 8'h3C, 8'h00, 0, 1'b0};
        tab[10] = '{K_ROM,     1'b1, 8'h04, 8'h00, 8'h3C, 1, 1'b0};
        tab[11] = '{K_ROM,     1'b0, 8'h03, 8'h00, 8'h5A, 1, 1'b0};
        tab[12] = '{K_ILL2,    1'b0, 8'h05, 8'h99, 8'h00, 0, 1'b0};
        tab[13] = '{K_RAMRD,   1'b0, 8'h05, 8'h00, 8'h11, 2, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("init_rdata", {24'd0, rdata}, 32'd0);
        check("init_rdy", {31'd0, rdy}, 32'd0);
        check("init_busy", {31'd0, busy}, 32'd0);
        check("init_err", {31'd0, err}, 32'd0);
        check("init0_rdata", {24'd0, rdata0}, 32'd0);
        check("init0_busy", {31'd0, busy0}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            do_access(i, tab[i]);
        end

        // Reset in the middle of a RAM write of 0xFF to address 5
        v = '{K_RAMWR, 1'b0, 8'h05, 8'hFF, 8'h00, 2, 1'b0};
        drive(v);
        @(posedge clk); #1;
        clear_inputs();
        check("rstw_busy_e0", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rstw_rdata", {24'd0, rdata}, 32'd0);
        check("rstw_busy", {31'd0, busy}, 32'd0);
        check("rstw_rdy", {31'd0, rdy}, 32'd0);
        check("rstw_err", {31'd0, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rstw_rdy_held", {31'd0, rdy}, 32'd0);
        check("rstw_busy_held", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        do_access(20, '{K_RAMRD, 1'b0, 8'h05, 8'h00, 8'h11, 2, 1'b0});
        do_access(21, '{K_ROM, 1'b1, 8'h04, 8'h00, 8'h3C, 1, 1'b0});

        // Zero-wait ROM instance: back-to-back accepts every two cycles
        pulse_reset();
        do_access(30, '{K_LOAD, 1'b0, 8'h07, 8'h81, 8'h00, 0, 1'b0});
        do_access(31, '{K_LOAD, 1'b0, 8'h08, 8'h42, 8'h00, 0, 1'b0});
        ad_sel   = 1'b0;
        rom_ena0 = 1'b1;
        rom_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pc_addr = (((i / 2) % 2) == 1) ? 8'h08 : 8'h07;
            @(posedge clk); #1;
            exp_rd = (((i / 2) % 2) == 1) ? 8'h42 : 8'h81;
            check($sformatf("zw_rdy_%0d", i), {31'd0, rdy0}, ((i % 2) == 0) ? 32'd1 : 32'd0);
            check($sformatf("zw_busy_%0d", i), {31'd0, busy0}, ((i % 2) == 0) ? 32'd1 : 32'd0);
            check($sformatf("zw_rdata_%0d", i), {24'd0, rdata0}, {24'd0, exp_rd});
            check($sformatf("zw_main_idle_%0d", i), {31'd0, busy}, 32'd0);
        end
        rom_ena0 = 1'b0;
        rom_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the CPU controller's bus strobes. It accepts the ROM-read, RAM-read and RAM-write requests the controller issues, selects the address with `ad_sel`, and inserts a configurable number of wait states. It then completes the access with a one-cycle `rdy` pulse. It owns the instruction ROM (preloadable while idle) and the data RAM, and sits between the controller/datapath and storage.

## Interface
- `ADDR_W`, 8: address width; each array is 2**ADDR_W words.
- `DATA_W`, 8: data word width.
- `ROM_WAIT`, 1: wait states for a ROM read, range 0..15.
- `RAM_WAIT`, 2: wait states for a RAM read or write, range 0..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rom_ena`, `rom_read` in 1: ROM read request when both are high.
- `ram_ena`, `ram_read`, `ram_write` in 1: RAM read request is `ram_ena & ram_read`; RAM write request is `ram_ena & ram_write`.
- `ad_sel` in 1: address select; 0 selects `pc_addr`, 1 selects `ir_addr`.
- `pc_addr`, `ir_addr` in ADDR_W: candidate addresses.
- `wdata` in DATA_W: RAM write data.
- `ld_en` in 1, `ld_addr` in ADDR_W, `ld_data` in DATA_W: ROM preload port.
- `rdata` out DATA_W: last completed read data.
- `rdy` out 1: access-complete pulse.
- `busy` out 1: high whenever the state is not IDLE.
- `err` out 1: illegal-request pulse.

## Operation
- States: IDLE, WAIT, RESP.
- Requests are sampled only in IDLE, on the rising edge.
- Request decode: `rr = rom_ena & rom_read`, `mr = ram_ena & ram_read`, `mw = ram_ena & ram_write`.
- `ld_en` in IDLE has the highest priority:
  - writes `rom[ld_addr] = ld_data`;
  - any request in the same cycle is ignored; no `err`.
- `ld_en` in WAIT or RESP is ignored.
- Exactly one of `rr`/`mr`/`mw` high (and no `ld_en`): the request is accepted.
  - Latch the operation, `addr = ad_sel ? ir_addr : pc_addr`, and `wdata`.
  - Load the counter with ROM_WAIT (ROM read) or RAM_WAIT (RAM access).
  - If the wait count is 0, go to RESP; otherwise go to WAIT.
- Two or more of `rr`/`mr`/`mw` high: no access, stay in IDLE, `err` = 1 for the next cycle.
- WAIT: the counter decrements each cycle; on the edge where it reaches 0, go to RESP.
- Access is performed on the edge that enters RESP:
  - ROM read: `rdata <= rom[addr]`.
  - RAM read: `rdata <= ram[addr]`.
  - RAM write: `ram[addr] <= wdata`; `rdata` is unchanged.
- RESP: `rdy` = 1 for exactly one cycle, then the next edge returns to IDLE.
- Requests that change or drop during WAIT/RESP have no effect, because the latched values are used.
- Arrays have no reset and power up undefined; the bench preloads before use.

## Timing
- Reset values: state IDLE, `rdata` = 0, `rdy` = 0, `busy` = 0, `err` = 0, counter = 0.
- Reset mid-access aborts the access: no pending write commits, `rdata` is not updated, and no `rdy` is issued.
- With acceptance at edge E0 and wait count W:
  - `busy` is high from E0 to E0+W+1.
  - `rdy` is high from E0+W to E0+W+1.
  - `rdata` is valid from E0+W onward and holds until the next completed read.
- The earliest next acceptance is edge E0+W+2, so the minimum request period is W+2 cycles.
- `err` is registered, one cycle wide, and asserted in the cycle after the illegal sample.
- Counter width is 4 bits.

## Structure
- Shared package `mem_bus_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - the operation enum (OP_ROM_RD, OP_RAM_RD, OP_RAM_WR);
  - the default ADDR_W/DATA_W and the maximum wait count of 15.
- Sub-module `mem_sp_array`: single-port array with synchronous write and an asynchronous-index read, registered by the parent.
  - Instantiated twice: ROM (write port driven by preload) and RAM (write port driven by the commit).

## Test plan
- ROM preload and read:
  - Stimulus: `ld_en` writes `rom[3]` = 0x5A; then `rom_ena` = `rom_read` = 1, `ad_sel` = 0, `pc_addr` = 3, accepted at E0.
  - Required: `rdy` high E1–E2 only, `rdata` = 0x5A, `busy` high E0–E2.
- RAM write then read:
  - Stimulus: write 0xC3 with `ir_addr` = 0x10, `ad_sel` = 1; then read the same address.
  - Required: each access gives `rdy` exactly at E0+2; the read returns 0xC3; `rdata` is unchanged by the write.
- Illegal request:
  - Stimulus: `ram_ena` = `ram_read` = `ram_write` = 1.
  - Required: `err` pulse for one cycle, `busy` stays 0, no `rdy`, RAM contents unchanged.
- Reset mid-write:
  - Stimulus: RAM write of 0xFF to address 5 accepted at E0; `rst` asserted before E2.
  - Required: `ram[5]` keeps its old value, `rdy` never pulses, all outputs read 0.
- Busy-ignore and preload priority:
  - Stimulus: a second request during WAIT; `ld_en` together with a request in IDLE.
  - Required: the second request is ignored; the ROM load happens, the request is dropped, and there is no `err`.
- Zero-wait build (ROM_WAIT = 0):
  - Stimulus: ROM read accepted at E0.
  - Required: `rdy` from E0 to E1; back-to-back accepts every 2 cycles.
